// File: rtl/pingpong_buf.sv
// Serial single-bit ping-pong buffer: one bank captures while the other plays back.
// A one-cycle switch strobe swaps bank roles and restarts both pointers.
module pingpong_buf #(
    parameter int MAX_COUNT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic switch,
    input  logic bit_in,
    output logic bit_out
);

    localparam int IW = $clog2(MAX_COUNT);
    localparam logic [IW-1:0] LAST = IW'(MAX_COUNT - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    logic                 sel_q, sel_d;
    logic [IW-1:0]        wr_idx_q, wr_idx_d;
    logic [IW-1:0]        rd_idx_q, rd_idx_d;
    logic [MAX_COUNT-1:0] bank_a_q, bank_a_d;
    logic [MAX_COUNT-1:0] bank_b_q, bank_b_d;

    // Next-state: swap on strobe, otherwise write one bit and advance both pointers
    always_comb begin
        sel_d    = sel_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        bank_a_d = bank_a_q;
        bank_b_d = bank_b_q;
        if (switch) begin
            sel_d    = ~sel_q;
            wr_idx_d = '0;
            rd_idx_d = '0;
        end else begin
            if (sel_q) begin
                bank_b_d[wr_idx_q] = bit_in;
            end else begin
                bank_a_d[wr_idx_q] = bit_in;
            end
            wr_idx_d = (wr_idx_q == LAST) ? '0 : wr_idx_q + ONE;
            rd_idx_d = (rd_idx_q == LAST) ? '0 : rd_idx_q + ONE;
        end
    end

    // State registers with asynchronous clear of pointers and both banks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q    <= 1'b0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            bank_a_q <= '0;
            bank_b_q <= '0;
        end else begin
            sel_q    <= sel_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            bank_a_q <= bank_a_d;
            bank_b_q <= bank_b_d;
        end
    end

    // Playback comes purely from registered state: B when sel=0, A when sel=1
    assign bit_out = sel_q ? bank_a_q[rd_idx_q] : bank_b_q[rd_idx_q];

endmodule

// File: tb/tb_pingpong_buf.sv
// Directed bench for pingpong_buf with MAX_COUNT=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pingpong_buf;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic switch = 1'b0;
    logic bit_in = 1'b0;
    logic bit_out;

    int total = 0;
    int bad = 0;

    pingpong_buf #(.MAX_COUNT(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .switch (switch),
        .bit_in (bit_in),
        .bit_out(bit_out)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_swap(input logic b);
        switch = 1'b1;
        bit_in = b;
        step();
        switch = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        switch = 1'b0;
        bit_in = 1'b0;
        step();
        step();
        total++;
        if (bit_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: got %b want 0", bit_out);
        end
        rst = 1'b0;
        #1;
        total++;
        if (bit_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got %b want 0", bit_out);
        end
        for (int i = 0; i < N; i++) begin
            step();
            total++;
            if (bit_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle[%0d]: got %b want 0", i, bit_out);
            end
        end
    endtask

    task automatic test_basic_swap();
        for (int i = 0; i < N; i++) begin
            bit_in = 1'b1;
            step();
        end
        do_swap(1'b0);
        bit_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (bit_out !== 1'b1) begin
                bad++;
                $display("FAIL basic_swap[%0d]: got %b want 1", i, bit_out);
            end
            step();
        end
    endtask

    task automatic test_second_swap();
        do_swap(1'b0);
        bit_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (bit_out !== 1'b0) begin
                bad++;
                $display("FAIL second_swap[%0d]: got %b want 0", i, bit_out);
            end
            step();
        end
    endtask

    task automatic test_pattern();
        logic [7:0] pat;
        pat = 8'b0100_1101;
        for (int i = 0; i < N; i++) begin
            bit_in = pat[i];
            step();
        end
        do_swap(1'b0);
        bit_in = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            total++;
            if (bit_out !== pat[i % N]) begin
                bad++;
                $display("FAIL pattern[%0d]: got %b want %b",
                         i, bit_out, pat[i % N]);
            end
            step();
        end
    endtask

    task automatic test_swap_discard();
        do_swap(1'b1);
        bit_in = 1'b0;
        for (int i = 0; i < N; i++) begin
            total++;
            if (bit_out !== 1'b0) begin
                bad++;
                $display("FAIL discard_old[%0d]: got %b want 0", i, bit_out);
            end
            step();
        end
        do_swap(1'b0);
        for (int i = 0; i < N; i++) begin
            total++;
            if (bit_out !== 1'b0) begin
                bad++;
                $display("FAIL discard_new[%0d]: got %b want 0", i, bit_out);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < N; i++) begin
            bit_in = 1'b1;
            step();
        end
        do_swap(1'b0);
        bit_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bit_out !== 1'b1) begin
                bad++;
                $display("FAIL pre_reset[%0d]: got %b want 1", i, bit_out);
            end
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (bit_out !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got %b want 0", bit_out);
        end
        step();
        rst = 1'b0;
        bit_in = 1'b1;
        for (int i = 0; i < N; i++) begin
            total++;
            if (bit_out !== 1'b0) begin
                bad++;
                $display("FAIL post_reset[%0d]: got %b want 0", i, bit_out);
            end
            step();
        end
        bit_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_swap();
        test_second_swap();
        test_pattern();
        test_swap_discard();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pingpong_buf.md
# pingpong_buf

Serial single-bit ping-pong (double) buffer of two banks, A and B, each MAX_COUNT bits deep. One bank captures the incoming bit stream while the other plays back its previously captured contents. A single-cycle `switch` strobe swaps the roles of the banks. The block sits between a serial bit source and a downstream consumer that needs a full frame of bits held stable while the next frame is captured.

## Interface
- `MAX_COUNT`, default 1024: depth of each bank in bits; legal range ≥ 2.
- Index width is `$clog2(MAX_COUNT)`.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `switch`, input, 1: bank swap strobe, sampled on a rising `clk` edge.
- `bit_in`, input, 1: serial write data.
- `bit_out`, output, 1: serial read data from the read bank.

## Operation
- State:
  - `sel`: 0 means write A / read B; 1 means write B / read A.
  - `wr_idx`: write pointer.
  - `rd_idx`: read pointer.
  - Bank A and bank B storage, MAX_COUNT bits each.
- Reset (`rst`=1, asynchronous) sets `sel`=0, `wr_idx`=0, `rd_idx`=0 and clears both banks to 0. `bit_out`=0 during and after reset until data is swapped in.
- Normal cycle (`switch`=0):
  - Write bank[`wr_idx`] ← `bit_in`.
  - `wr_idx` increments; after MAX_COUNT−1 it wraps to 0, overwriting from the start.
  - `rd_idx` increments, wrapping to 0 after MAX_COUNT−1.
  - Playback of the read bank therefore repeats every MAX_COUNT cycles.
- Swap cycle (`switch`=1 at a rising edge):
  - `sel` toggles.
  - `wr_idx` and `rd_idx` both go to 0.
  - `bit_in` on the swap cycle is discarded (no write).
  - The bank just filled becomes the read bank. Its contents are retained intact.
  - The new write bank is not cleared; it is overwritten bit by bit.
- `bit_out` is combinational: `bit_out` = read_bank[`rd_idx`], where read_bank = B when `sel`=0 and A when `sel`=1.
- A partial fill is not flagged. A swap after fewer than MAX_COUNT writes leaves stale bits above the last written index in the new read bank.
- Back-to-back swaps are legal. Each swap toggles `sel` and zeroes both pointers.

## Timing
- Write latency: a bit written at edge N is readable only after a subsequent swap.
- After a swap at edge S, `bit_out` = new_read_bank[0] during cycle S..S+1.
- `bit_out` = new_read_bank[k] during the cycle after edge S+k, for k < MAX_COUNT.
- Write index k of a frame is written at edge S+k+1.
- `bit_out` changes only after a rising `clk` edge or on reset assertion. It has no dependency on `bit_in` or `switch` within the same cycle.
- Reset asserted mid-frame clears everything immediately. The first post-reset write goes to bank A index 0.

## Test plan
- Reset: assert `rst`, then release → `bit_out`=0; 8 idle cycles with `bit_in`=0 → `bit_out` stays 0 (bank B empty).
- Basic swap (MAX_COUNT=8): 8 cycles `bit_in`=1 into A, then a 1-cycle `switch`, then 8 cycles `bit_in`=0 → `bit_out`=1 on all 8 cycles.
- Second swap: continue from the previous scenario with another `switch` → `bit_out`=0 for 8 cycles (B holds zeros).
- Pattern order: write 1,0,1,1,0,0,1,0, then swap → `bit_out` reads 1,0,1,1,0,0,1,0 in that order, then repeats the same 8 bits.
- Swap-cycle discard: hold `bit_in`=1 on the swap cycle with the following writes all 0; swap again → new read bank reads all 0 (the swap-cycle bit was not written).
- Async reset mid-frame: after the basic swap, assert `rst` between edges during readout → `bit_out`=0 immediately; after release, `bit_out` remains 0.
